// File: rtl/ebpc_pkg.sv
// Shared types and constants for the EBPC bit-plane path: block geometry,
// the delta bit-plane block handed between stages, and the serialized beat.
package ebpc_pkg;

  localparam int DATA_W      = 8;
  localparam int BLOCK_SIZE  = 8;
  localparam int N_PLANES    = DATA_W + 1;
  localparam int PLANE_W     = BLOCK_SIZE - 1;
  localparam int PLANE_CNT_W = $clog2(N_PLANES);

  typedef logic [PLANE_W-1:0] plane_t;

  // dbp[0] is the MSB plane, dbp[DATA_W] the LSB plane.
  typedef struct packed {
    plane_t [N_PLANES-1:0] dbp;
    logic [DATA_W-1:0]     base;
    logic                  flush;
  } dbp_block_t;

  typedef struct packed {
    plane_t                 dbp;
    plane_t                 dbx;
    logic [PLANE_CNT_W-1:0] plane_idx;
    logic                   first;
    logic                   last;
    logic                   flush;
  } dbx_beat_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  // Plane 0 has no predecessor, so it passes through unchanged.
  function automatic plane_t dbx_of(input plane_t cur, input plane_t prev, input logic first);
    return first ? cur : (cur ^ prev);
  endfunction

endpackage

// File: rtl/dbx_plane_serializer.sv
// Emits a captured delta bit-plane block one plane per cycle, MSB plane first,
// alongside its DBX plane. Optional zero-run outputs under DBX_ZERO_RUN_EN.
module dbx_plane_serializer
  import ebpc_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  dbp_block_t             dbp_block_i,
  input  logic                   vld_i,
  output logic                   rdy_o,
  output logic [BLOCK_SIZE-2:0]  dbp_o,
  output logic [BLOCK_SIZE-2:0]  dbx_o,
  output logic [DATA_W-1:0]      base_o,
  output logic [PLANE_CNT_W-1:0] plane_idx_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic                   flush_o,
  output logic                   vld_o,
  input  logic                   rdy_i,
  output logic                   idle_o
`ifdef DBX_ZERO_RUN_EN
  ,
  output logic                   dbx_zero_o,
  output logic [PLANE_CNT_W:0]   zero_run_o
`endif
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // valid never waits on ready, and rdy_o looks at rdy_i only on the last beat.

  ser_state_e             state_q, state_d;
  dbp_block_t             blk_q;
  logic [PLANE_CNT_W-1:0] cnt_q, cnt_d;
  logic [PLANE_CNT_W-1:0] prev_idx;
  logic                   load;
  logic                   hs;
  logic                   last_beat;
  dbx_beat_t              beat;

  assign last_beat = (cnt_q == PLANE_CNT_W'(DATA_W));
  assign prev_idx  = cnt_q - 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    hs      = 1'b0;
    rdy_o   = 1'b0;
    vld_o   = 1'b0;
    idle_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_o  = 1'b1;
        idle_o = 1'b1;
        if (vld_i) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        vld_o = 1'b1;
        if (rdy_i) begin
          hs = 1'b1;
          if (!last_beat) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Last beat frees the block register, so a waiting block loads with no bubble.
            rdy_o = 1'b1;
            cnt_d = '0;
            if (vld_i) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    beat = '0;
    if (state_q == ST_STREAM) begin
      beat.dbp       = blk_q.dbp[cnt_q];
      beat.dbx       = dbx_of(blk_q.dbp[cnt_q], blk_q.dbp[prev_idx], cnt_q == '0);
      beat.plane_idx = cnt_q;
      beat.first     = (cnt_q == '0);
      beat.last      = last_beat;
      beat.flush     = blk_q.flush & last_beat;
    end
  end

  assign dbp_o       = beat.dbp;
  assign dbx_o       = beat.dbx;
  assign plane_idx_o = beat.plane_idx;
  assign first_o     = beat.first;
  assign last_o      = beat.last;
  assign flush_o     = beat.flush;
  assign base_o      = (state_q == ST_STREAM) ? blk_q.base : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        blk_q <= dbp_block_i;
      end
    end
  end

`ifdef DBX_ZERO_RUN_EN
  logic [PLANE_CNT_W:0] zero_run_q;

  // Counts all-zero DBX planes already sent in this block; any non-zero plane restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zero_run_q <= '0;
    end else if (load || (hs && last_beat)) begin
      zero_run_q <= '0;
    end else if (hs) begin
      zero_run_q <= (beat.dbx == '0) ? zero_run_q + 1'b1 : '0;
    end
  end

  assign dbx_zero_o = (dbx_o == '0);
  assign zero_run_o = zero_run_q;
`endif

endmodule

// File: tb/tb_dbx_plane_serializer.sv
// Directed bench for dbx_plane_serializer: vector table of blocks with
// hand-computed DBX planes, scoreboard of expected beats, corner sequences.
module tb_dbx_plane_serializer;
  import ebpc_pkg::*;

  localparam int W = 29;

  typedef struct {
    logic [8:0][6:0] dbp;
    logic [7:0]      base;
    logic            flush;
    logic [8:0][6:0] exp_dbx;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b1;
  dbp_block_t             dbp_block_i = '0;
  logic                   vld_i = 1'b0;
  logic                   rdy_o;
  logic [BLOCK_SIZE-2:0]  dbp_o;
  logic [BLOCK_SIZE-2:0]  dbx_o;
  logic [DATA_W-1:0]      base_o;
  logic [PLANE_CNT_W-1:0] plane_idx_o;
  logic                   first_o, last_o, flush_o, vld_o, idle_o;
  logic                   rdy_i = 1'b1;
`ifdef DBX_ZERO_RUN_EN
  logic                   dbx_zero_o;
  logic [PLANE_CNT_W:0]   zero_run_o;
  logic [PLANE_CNT_W:0]   zr_q[$];
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  vec_t        vecs[4];
  logic        mon_en = 1'b0;
  logic        bp_en = 1'b0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          first_hs = 0;
  int          last_hs = 0;
  logic [W-1:0] act_beat;

  dbx_plane_serializer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .dbp_block_i (dbp_block_i),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .dbp_o       (dbp_o),
    .dbx_o       (dbx_o),
    .base_o      (base_o),
    .plane_idx_o (plane_idx_o),
    .first_o     (first_o),
    .last_o      (last_o),
    .flush_o     (flush_o),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .idle_o      (idle_o)
`ifdef DBX_ZERO_RUN_EN
    ,
    .dbx_zero_o  (dbx_zero_o),
    .zero_run_o  (zero_run_o)
`endif
  );

  assign act_beat = {plane_idx_o, first_o, last_o, flush_o, base_o, dbp_o, dbx_o};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) rdy_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic set_plane(input int i, input int k, input logic [6:0] d, input logic [6:0] x);
    vecs[i].dbp[k]     = d;
    vecs[i].exp_dbx[k] = x;
  endtask

  function automatic logic [W-1:0] exp_beat(input int i, input int k);
    logic [3:0] idx;
    idx = 4'(k);
    return {idx, k == 0, k == 8, vecs[i].flush && (k == 8), vecs[i].base,
            vecs[i].dbp[k], vecs[i].exp_dbx[k]};
  endfunction

  task automatic push_block(input int i);
`ifdef DBX_ZERO_RUN_EN
    logic [PLANE_CNT_W:0] zr;
    zr = '0;
`endif
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(exp_beat(i, k));
`ifdef DBX_ZERO_RUN_EN
      if (k == 0) zr = '0;
      else if (vecs[i].exp_dbx[k-1] == 7'h00) zr = zr + 1'b1;
      else zr = '0;
      zr_q.push_back(zr);
`endif
    end
  endtask

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic drive_block(input int i);
    int   waited;
    logic done;
    dbp_block_i.dbp   = vecs[i].dbp;
    dbp_block_i.base  = vecs[i].base;
    dbp_block_i.flush = vecs[i].flush;
    vld_i  = 1'b1;
    push_block(i);
    waited = 0;
    done   = 1'b0;
    while (!done && waited < 200) begin
      #1;
      if (rdy_o) done = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (!done) fail_now("accept_timeout");
    else check("first_beat_latency", vld_o, 1'b1);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !idle_o) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) fail_now("drain_timeout");
    @(negedge clk);
    #3;
    check("idle_after_block", idle_o, 1'b1);
    check("vld_after_block", vld_o, 1'b0);
    @(negedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    #2;
    if (mon_en && !rst_i) begin
      if (vld_o) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          check("beat", act_beat, exp_q[0]);
          check("rdy_o_stream", rdy_o, exp_q[0][W-6] & rdy_i);
          check("idle_o_stream", idle_o, 1'b0);
`ifdef DBX_ZERO_RUN_EN
          check("dbx_zero", dbx_zero_o, exp_q[0][6:0] == 7'h00);
          check("zero_run", zero_run_o, zr_q[0]);
`endif
          if (rdy_i) begin
            void'(exp_q.pop_front());
`ifdef DBX_ZERO_RUN_EN
            void'(zr_q.pop_front());
`endif
            hs_cnt++;
            if (hs_cnt == 1) first_hs = cyc;
            last_hs = cyc;
          end
        end
      end else begin
        check("rdy_o_idle", rdy_o, 1'b1);
        check("idle_o_idle", idle_o, 1'b1);
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    int w;
    for (int i = 0; i < 4; i++) begin
      vecs[i].dbp     = '0;
      vecs[i].exp_dbx = '0;
    end
    // all-zero planes
    vecs[0].base = 8'h12; vecs[0].flush = 1'b0;
    // alternating 55/2A planes
    vecs[1].base = 8'h3C; vecs[1].flush = 1'b0;
    set_plane(1, 0, 7'h55, 7'h55);
    for (int k = 1; k < 9; k++) set_plane(1, k, (k % 2 == 0) ? 7'h55 : 7'h2A, 7'h7F);
    // growing mask, flush set
    vecs[2].base = 8'hA5; vecs[2].flush = 1'b1;
    set_plane(2, 0, 7'h01, 7'h01);
    set_plane(2, 1, 7'h03, 7'h02);
    set_plane(2, 2, 7'h07, 7'h04);
    set_plane(2, 3, 7'h0F, 7'h08);
    set_plane(2, 4, 7'h1F, 7'h10);
    set_plane(2, 5, 7'h3F, 7'h20);
    set_plane(2, 6, 7'h7F, 7'h40);
    set_plane(2, 7, 7'h7F, 7'h00);
    set_plane(2, 8, 7'h00, 7'h7F);
    // zero runs: dbx 0,0,0,5,0,F,0,0,0
    vecs[3].base = 8'hF0; vecs[3].flush = 1'b0;
    set_plane(3, 0, 7'h00, 7'h00);
    set_plane(3, 1, 7'h00, 7'h00);
    set_plane(3, 2, 7'h00, 7'h00);
    set_plane(3, 3, 7'h05, 7'h05);
    set_plane(3, 4, 7'h05, 7'h00);
    set_plane(3, 5, 7'h0A, 7'h0F);
    set_plane(3, 6, 7'h0A, 7'h00);
    set_plane(3, 7, 7'h0A, 7'h00);
    set_plane(3, 8, 7'h0A, 7'h00);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_vld_o", vld_o, 1'b0);
    check("rst_rdy_o", rdy_o, 1'b1);
    check("rst_idle_o", idle_o, 1'b1);
    check("rst_dbp_o", dbp_o, 7'h00);
    check("rst_dbx_o", dbx_o, 7'h00);
    check("rst_base_o", base_o, 8'h00);
    check("rst_plane_idx_o", plane_idx_o, 4'h0);
    check("rst_first_last_flush", {first_o, last_o, flush_o}, 3'b000);
    @(negedge clk);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // single blocks at full rate, table-driven
    for (int i = 0; i < 4; i++) begin
      drive_block(i);
      vld_i = 1'b0;
      wait_drain();
    end

    // back-to-back: three blocks, no gaps
    hs_cnt = 0;
    drive_block(1);
    drive_block(2);
    drive_block(0);
    vld_i = 1'b0;
    wait_drain();
    check("b2b_beats", hs_cnt, 27);
    check("b2b_span", last_hs - first_hs + 1, 27);

    // backpressure
    bp_en = 1'b1;
    drive_block(3);
    drive_block(2);
    drive_block(1);
    vld_i = 1'b0;
    wait_drain();
    bp_en = 1'b0;
    @(negedge clk);

    // reset asserted during beat 4
    drive_block(2);
    vld_i = 1'b0;
    w = 0;
    while (!(vld_o && plane_idx_o == 4'd4) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) fail_now("beat4_timeout");
    mon_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    check("midrst_vld_o", vld_o, 1'b0);
    check("midrst_rdy_o", rdy_o, 1'b1);
    exp_q.delete();
`ifdef DBX_ZERO_RUN_EN
    zr_q.delete();
`endif
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("postrst_idle_o", idle_o, 1'b1);
    check("postrst_plane_idx_o", plane_idx_o, 4'h0);
    @(negedge clk);
    mon_en = 1'b1;
    drive_block(3);
    vld_i = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
